io_timer_bank: RTL
==================

Name: io_timer_bank

Overview:
- Parametrised memory-mapped timer peripheral on the mmu IO bus (io_addr/io_en/io_we/io_data_write/io_data_read).
- Replaces the static IO word array used under core simulation with NUM_CH real countdown timers, a shared prescaler and an interrupt line.
- Read data is combinational, so the existing mmu IO timing is unchanged.

Parameters:
- NUM_CH, 4, number of timer channels, 1..15.
- CNT_W, 32, counter/load width, 1..32; zero-extended onto the 32-bit read bus.
- PRESC_W, 8, prescaler width, 1..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high; all state cleared immediately on assertion.
- io_en  in  1  IO access strobe from mmu.
- io_we  in  1  write enable; effective only with io_en.
- io_addr  in  8  byte address; bits [1:0] ignored.
- io_data_write  in  32  write data.
- io_data_read  out  32  read data, combinational from io_addr; 0 when io_en=0.
- irq  out  1  registered; OR over channels of (EXP & IE).

Behaviour:
- Map: channel c at byte base c*0x10. +0x0 CTRL [0]EN [1]AR(auto-reload) [2]IE. +0x4 LOAD. +0x8 COUNT (read/write). +0xC STATUS [0]EXP, write-1-to-clear.
- Globals: 0xF0 PRESC (R/W). 0xFC PEND (RO, bit c = EXP&IE of channel c).
- Unmapped or out-of-range (c >= NUM_CH) addresses read 0; writes to them are ignored.
- Reset values: all registers 0, prescaler counter 0, irq 0, io_data_read 0.
- Prescaler: pcnt counts up each clk. tick=1 when pcnt==PRESC; pcnt returns to 0 on that edge. PRESC=0 gives a tick every cycle. Writing PRESC clears pcnt.
- Channel update happens on a tick edge with EN=1:
  - COUNT>1: COUNT-1.
  - COUNT<=1 (expiry): EXP<=1. If AR=1, COUNT<=LOAD. Otherwise COUNT<=0 and EN<=0 (one-shot).
  - AR=1 with LOAD=0: expires every tick.
  - Period with AR=1 is max(LOAD,1) ticks.
- EN=0: COUNT holds.
- Writes take effect on the clk edge with io_en&io_we. Register widths are truncated to CNT_W/PRESC_W.
- Simultaneous events:
  - Bus write to COUNT or CTRL beats the timer update on the same edge. A CTRL write of EN=1 persists over a one-shot clear.
  - STATUS W1C coincident with expiry: set wins, EXP stays 1.
  - Writing LOAD does not affect COUNT until the next reload.
- irq is registered one cycle after EXP&IE. It deasserts one cycle after the last pending bit clears.
- Reset mid-count: COUNT, EXP, EN and irq go to 0 asynchronously. No spurious irq follows reset release.

Optional Feature:
- Macro IO_TIMER_CYCLE_EN.
- Defined: adds a 64-bit free-running cycle counter, reset 0, wrapping.
  - Reading 0xF4 returns the low 32 bits. On that read cycle (io_en&~io_we), the high 32 bits are snapshotted into HI_LATCH.
  - 0xF8 returns HI_LATCH. Both addresses are read-only.
- Undefined: 0xF4/0xF8 read 0 and no counter logic is built.

Decomposition:
- Shared package io_timer_pkg holds:
  - Offsets OFS_CTRL=0x0, OFS_LOAD=0x4, OFS_COUNT=0x8, OFS_STATUS=0xC.
  - Global addresses ADDR_PRESC=0xF0, ADDR_CYC_LO=0xF4, ADDR_CYC_HI=0xF8, ADDR_PEND=0xFC.
  - CTRL bit indices EN/AR/IE and CH_STRIDE=0x10.
- Sub-module io_timer_channel (one per channel, generate loop) holds CTRL/LOAD/COUNT/EXP and the decrement/reload logic.
- The top level owns address decode, the prescaler, the read mux, PEND/irq and the optional cycle counter.

Test Plan:
- Reset, then read every mapped address -> all 0, irq=0. Read 0xE0 with NUM_CH=4 -> 0.
- PRESC=0, ch0 LOAD=5, COUNT=5, CTRL=0b101 (EN+IE, one-shot):
  - EXP set on the 5th clk edge after the CTRL write; irq rises 1 cycle later.
  - COUNT reads 0 and EN reads 0.
  - Write STATUS=1 -> irq drops 1 cycle later.
- PRESC=3, ch1 LOAD=2, CTRL=0b111 (auto-reload):
  - EXP every 8 clk cycles and COUNT sequence 2,1,2,1...
  - A W1C on the exact expiry edge leaves EXP=1.
- ch2 running. On the same edge as a tick, write COUNT=100 -> COUNT reads 100, not 99. Write CTRL=0 -> COUNT frozen.
- All 4 channels IE, with ch0 and ch3 expired -> PEND=0x9, irq=1. Assert reset mid-count -> irq, COUNT and PEND are 0 in the same cycle.
- With IO_TIMER_CYCLE_EN defined:
  - Read 0xF4 at cycle N, then read 0xF8 -> the 64-bit value is consistent with N, and HI_LATCH is stable across the low-word wrap.
  - With the macro undefined, both addresses read 0.

Source files
------------

// File: rtl/io_timer_pkg.sv
// Shared address map, CTRL bit positions and bus-side types for io_timer_bank.
package io_timer_pkg;

  // Per-channel register offsets (byte offsets inside a channel window)
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_LOAD   = 4'h4;
  localparam logic [3:0] OFS_COUNT  = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  // Global register addresses; the 0xF0 window is never a channel (NUM_CH <= 15)
  localparam logic [7:0] ADDR_PRESC  = 8'hF0;
  localparam logic [7:0] ADDR_CYC_LO = 8'hF4;
  localparam logic [7:0] ADDR_CYC_HI = 8'hF8;
  localparam logic [7:0] ADDR_PEND   = 8'hFC;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  localparam logic [7:0] CH_STRIDE = 8'h10;

  // CTRL register image, bit 0 = EN
  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  // One-hot register write strobes into a channel
  typedef struct packed {
    logic ctrl;
    logic load;
    logic count;
    logic status;
  } ch_wr_t;

endpackage

// File: rtl/io_timer_channel.sv
// One countdown timer: CTRL/LOAD/COUNT/EXP plus decrement, reload and one-shot stop.
module io_timer_channel
  import io_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  ch_wr_t           wr,
  input  logic [31:0]      wdata,
  output ctrl_t            ctrl,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic             exp
);

  logic update;
  logic expire;

  assign update = tick & ctrl.en;
  assign expire = update & (count <= CNT_W'(1));

  // CTRL: a bus write always wins, so a written EN=1 survives a one-shot stop
  always_ff @(posedge clk or posedge reset)
    if (reset)                    ctrl    <= '0;
    else if (wr.ctrl)             ctrl    <= {wdata[CTRL_IE], wdata[CTRL_AR], wdata[CTRL_EN]};
    else if (expire && !ctrl.ar)  ctrl.en <= 1'b0;

  // LOAD only matters at the next reload; it never touches COUNT directly
  always_ff @(posedge clk or posedge reset)
    if (reset)        load <= '0;
    else if (wr.load) load <= wdata[CNT_W-1:0];

  // COUNT: bus write beats the tick update on the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset)                   count <= '0;
    else if (wr.count)           count <= wdata[CNT_W-1:0];
    else if (update) begin
      if (count > CNT_W'(1))     count <= count - CNT_W'(1);
      else if (ctrl.ar)          count <= load;
      else                       count <= '0;
    end

  // EXP: set on expiry, write-1-to-clear; a coincident set wins
  always_ff @(posedge clk or posedge reset)
    if (reset)                         exp <= 1'b0;
    else if (expire)                   exp <= 1'b1;
    else if (wr.status && wdata[0])    exp <= 1'b0;

endmodule

// File: rtl/io_timer_bank.sv
// Memory-mapped timer bank on the mmu IO bus: address decode, shared prescaler,
// combinational read mux, PEND/irq, and NUM_CH io_timer_channel instances.
// Optional 64-bit cycle counter at 0xF4/0xF8 when IO_TIMER_CYCLE_EN is defined.
module io_timer_bank
  import io_timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        irq
);

  logic [7:0]               word;
  logic [3:0]               ch_sel;
  logic [3:0]               ofs;
  logic                     wr_en;
  logic                     tick;
  logic [PRESC_W-1:0]       presc;
  logic [PRESC_W-1:0]       pcnt;
  ch_wr_t [NUM_CH-1:0]      ch_wr;
  ctrl_t  [NUM_CH-1:0]      ch_ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_load;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_count;
  logic [NUM_CH-1:0]        ch_exp;
  logic [NUM_CH-1:0]        pend;
  logic [31:0]              rdata_ch;
  logic [31:0]              rdata_gl;
  logic                     unused_addr_lsb;

  // Byte lanes are ignored: decode on the word address only
  assign word            = {io_addr[7:2], 2'b00};
  assign ch_sel          = word[7:4];
  assign ofs             = word[3:0];
  assign wr_en           = io_en & io_we;
  assign unused_addr_lsb = ^io_addr[1:0];

  assign tick = (pcnt == presc);

  // Prescaler: counts 0..PRESC and restarts on each tick; a PRESC write restarts it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc <= '0;
      pcnt  <= '0;
    end else if (wr_en && word == ADDR_PRESC) begin
      presc <= io_data_write[PRESC_W-1:0];
      pcnt  <= '0;
    end else if (tick) begin
      pcnt  <= '0;
    end else begin
      pcnt  <= pcnt + PRESC_W'(1);
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel      = wr_en & (ch_sel == 4'(c));
    assign ch_wr[c] = '{ctrl:   sel & (ofs == OFS_CTRL),
                        load:   sel & (ofs == OFS_LOAD),
                        count:  sel & (ofs == OFS_COUNT),
                        status: sel & (ofs == OFS_STATUS)};
    assign pend[c]  = ch_exp[c] & ch_ctrl[c].ie;

    io_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .wr    (ch_wr[c]),
      .wdata (io_data_write),
      .ctrl  (ch_ctrl[c]),
      .load  (ch_load[c]),
      .count (ch_count[c]),
      .exp   (ch_exp[c])
    );
  end

  // irq lags PEND by one cycle in both directions
  always_ff @(posedge clk or posedge reset)
    if (reset) irq <= 1'b0;
    else       irq <= |pend;

`ifdef IO_TIMER_CYCLE_EN
  logic [63:0] cyc;
  logic [31:0] hi_latch;

  // Free-running cycle counter; reading the low word freezes the high word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cyc      <= '0;
      hi_latch <= '0;
    end else begin
      cyc <= cyc + 64'd1;
      if (io_en && !io_we && word == ADDR_CYC_LO) hi_latch <= cyc[63:32];
    end
`endif

  // Channel read mux; out-of-range channels fall through to 0
  always_comb begin
    rdata_ch = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_sel == 4'(c))
        case (ofs)
          OFS_CTRL:   rdata_ch = 32'(ch_ctrl[c]);
          OFS_LOAD:   rdata_ch = 32'(ch_load[c]);
          OFS_COUNT:  rdata_ch = 32'(ch_count[c]);
          OFS_STATUS: rdata_ch = 32'(ch_exp[c]);
          default:    rdata_ch = '0;
        endcase
  end

  // Global register read mux
  always_comb begin
    rdata_gl = '0;
    case (word)
      ADDR_PRESC:  rdata_gl = 32'(presc);
      ADDR_PEND:   rdata_gl = 32'(pend);
`ifdef IO_TIMER_CYCLE_EN
      ADDR_CYC_LO: rdata_gl = cyc[31:0];
      ADDR_CYC_HI: rdata_gl = hi_latch;
`endif
      default:     rdata_gl = '0;
    endcase
  end

  assign io_data_read = !io_en ? 32'd0 : (ch_sel == 4'hF) ? rdata_gl : rdata_ch;

endmodule
